// File: rtl/cdc_pkg.sv
// Shared types and helpers for the source side of the toggle request/acknowledge CDC handshake.
package cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } cdc_tx_state_t;

  localparam int CNT_W_MIN = 1;

  // Width of the BUSY timeout counter; a disabled timeout still keeps a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < CNT_W_MIN) ? CNT_W_MIN : w;
  endfunction

endpackage

// File: rtl/ack_sync_chain.sv
// Multi-flop synchronizer bringing the destination acknowledge toggle into the source clock.
module ack_sync_chain
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side end of a two-phase toggle handshake: accepts one word, toggles req_o,
// holds data_o stable and waits for the synchronized ack toggle, with an optional timeout flag.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 0
) (
  input  logic                  clk_s,
  input  logic                  rst_n,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int               CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  cdc_tx_state_t         r_state;
  cdc_tx_state_t         w_state_nxt;
  logic                  r_req;
  logic                  w_req_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  w_load;
  logic                  w_err_set;
  logic                  w_ack_sync;

  ack_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .i_clk  (clk_s),
    .i_rst_n(rst_n),
    .i_d    (ack_i),
    .o_q    (w_ack_sync)
  );

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // The word is captured on the same edge that toggles req, so data is never newer than req.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= s_data_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid_i) begin
          w_load      = 1'b1;
          w_req_nxt   = ~r_req;
          w_cnt_nxt   = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_ack_sync == r_req) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          // Flag only on the step that reaches the limit, so a clear while still waiting sticks.
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_err_set = (TIMEOUT > 0) && (w_cnt_nxt == CNT_MAX);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_err_nxt = w_err_set ? 1'b1 : (err_clr_i ? 1'b0 : r_err);
  end

  assign s_ready_o = (r_state == IDLE);
  assign data_o    = r_data;
  assign req_o     = r_req;
  assign done_o    = r_done;
  assign err_o     = r_err;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Scoreboard bench for cdc_hs_tx: loopback latency, busy-hold, timeout flag, async reset, random ack delays.
module tb_cdc_hs_tx;

  localparam int DW = 32;
  localparam int SS = 3;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [DW-1:0] data_o;
  logic          req;
  logic          ack_i;
  logic          ack_man = 1'b0;
  logic          loop_mode = 1'b1;
  logic          done;
  logic          err;
  logic          err_clr = 1'b0;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] sb[$];
  logic          exp_req = 1'b0;

  assign ack_i = loop_mode ? req : ack_man;

  always #5 clk = ~clk;

  cdc_hs_tx #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clk_s    (clk),
    .rst_n    (rst_n),
    .s_valid_i(s_valid),
    .s_data_i (s_data),
    .s_ready_o(s_ready),
    .data_o   (data_o),
    .req_o    (req),
    .ack_i    (ack_i),
    .done_o   (done),
    .err_o    (err),
    .err_clr_i(err_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    if ({req, data_o, s_ready, done, err} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL reset_hold got req=%0b data=%h rdy=%0b done=%0b err=%0b exp 0/0/1/0/0",
               req, data_o, s_ready, done, err);
      failures++;
    end
    checks++;
    rst_n = 1'b1;
    tick;
    tick;
    if ({req, data_o, s_ready, done, err} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL reset_idle got req=%0b data=%h rdy=%0b done=%0b err=%0b exp 0/0/1/0/0",
               req, data_o, s_ready, done, err);
      failures++;
    end
    checks++;
  endtask

  task automatic test_loopback;
    logic got;
    loop_mode = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    sb.push_back(32'hDEADBEEF);
    tick;
    s_valid = 1'b0;
    exp_req = ~exp_req;
    if (req !== exp_req || data_o !== 32'hDEADBEEF || s_ready !== 1'b0) begin
      $display("FAIL lb_accept got req=%0b data=%h rdy=%0b exp req=%0b data=deadbeef rdy=0",
               req, data_o, s_ready, exp_req);
      failures++;
    end
    checks++;
    for (int e = 1; e <= SS; e++) begin
      tick;
      if (done !== 1'b0 || s_ready !== 1'b0) begin
        $display("FAIL lb_wait edge=%0d got done=%0b rdy=%0b exp 0/0", e, done, s_ready);
        failures++;
      end
      checks++;
    end
    tick;
    if (done !== 1'b1 || s_ready !== 1'b1) begin
      $display("FAIL lb_done edge=%0d got done=%0b rdy=%0b exp 1/1", SS + 1, done, s_ready);
      failures++;
    end
    checks++;
    if (sb.size() == 0 || data_o !== sb[0]) begin
      $display("FAIL lb_sb1 got data=%h exp=%h", data_o, (sb.size() != 0) ? sb[0] : 32'hx);
      failures++;
    end
    checks++;
    if (sb.size() != 0) void'(sb.pop_front());
    s_valid = 1'b1;
    s_data = 32'h12345678;
    sb.push_back(32'h12345678);
    tick;
    s_valid = 1'b0;
    exp_req = ~exp_req;
    if (req !== exp_req || done !== 1'b0 || data_o !== 32'h12345678) begin
      $display("FAIL lb_second got req=%0b done=%0b data=%h exp req=%0b done=0 data=12345678",
               req, done, data_o, exp_req);
      failures++;
    end
    checks++;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick;
      if (done) got = 1'b1;
    end
    if (!got || sb.size() == 0 || data_o !== sb[0]) begin
      $display("FAIL lb_sb2 got done=%0b data=%h exp done=1 data=12345678", got, data_o);
      failures++;
    end
    checks++;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_hold_valid;
    logic got;
    loop_mode = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    sb.push_back(32'hDEADBEEF);
    tick;
    exp_req = ~exp_req;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      s_data = $urandom;
      tick;
      if (done) begin
        got = 1'b1;
        if (sb.size() == 0 || data_o !== sb[0]) begin
          $display("FAIL hold_done_data got=%h exp=deadbeef", data_o);
          failures++;
        end
        checks++;
        if (sb.size() != 0) void'(sb.pop_front());
      end else begin
        if (data_o !== 32'hDEADBEEF || req !== exp_req) begin
          $display("FAIL hold_busy got data=%h req=%0b exp data=deadbeef req=%0b",
                   data_o, req, exp_req);
          failures++;
        end
        checks++;
      end
    end
    if (!got) begin
      $display("FAIL hold_timeout got done=0 exp done=1");
      failures++;
      checks++;
    end
    s_data = 32'hCAFEF00D;
    sb.push_back(32'hCAFEF00D);
    tick;
    s_valid = 1'b0;
    exp_req = ~exp_req;
    if (data_o !== 32'hCAFEF00D || req !== exp_req) begin
      $display("FAIL hold_next got data=%h req=%0b exp data=cafef00d req=%0b", data_o, req, exp_req);
      failures++;
    end
    checks++;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick;
      if (done) got = 1'b1;
    end
    if (!got || sb.size() == 0 || data_o !== sb[0]) begin
      $display("FAIL hold_sb got done=%0b data=%h exp done=1 data=cafef00d", got, data_o);
      failures++;
    end
    checks++;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_timeout;
    logic got;
    ack_man = exp_req;
    loop_mode = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h0BADF00D;
    sb.push_back(32'h0BADF00D);
    tick;
    s_valid = 1'b0;
    exp_req = ~exp_req;
    for (int e = 1; e < TO; e++) begin
      tick;
      if (err !== 1'b0) begin
        $display("FAIL to_early edge=%0d got err=%0b exp 0", e, err);
        failures++;
      end
      checks++;
    end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    if (err !== 1'b1) begin
      $display("FAIL to_set_wins edge=%0d got err=%0b exp 1", TO, err);
      failures++;
    end
    checks++;
    tick;
    tick;
    if (err !== 1'b1) begin
      $display("FAIL to_sticky got err=%0b exp 1", err);
      failures++;
    end
    checks++;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    if (err !== 1'b0) begin
      $display("FAIL to_clear got err=%0b exp 0", err);
      failures++;
    end
    checks++;
    tick;
    tick;
    if (err !== 1'b0 || s_ready !== 1'b0 || req !== exp_req) begin
      $display("FAIL to_still_busy got err=%0b rdy=%0b req=%0b exp 0/0/%0b", err, s_ready, req, exp_req);
      failures++;
    end
    checks++;
    ack_man = exp_req;
    got = 1'b0;
    for (int k = 0; k < SS + 4 && !got; k++) begin
      tick;
      if (done) got = 1'b1;
    end
    if (!got || sb.size() == 0 || data_o !== sb[0]) begin
      $display("FAIL to_complete got done=%0b data=%h exp done=1 data=0badf00d", got, data_o);
      failures++;
    end
    checks++;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_async_reset;
    logic got;
    loop_mode = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h55AA55AA;
    tick;
    s_valid = 1'b0;
    tick;
    if (req !== ~exp_req || s_ready !== 1'b0) begin
      $display("FAIL rst_pre got req=%0b rdy=%0b exp req=%0b rdy=0", req, s_ready, ~exp_req);
      failures++;
    end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({req, data_o, s_ready, done, err} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL rst_async got req=%0b data=%h rdy=%0b done=%0b err=%0b exp 0/0/1/0/0",
               req, data_o, s_ready, done, err);
      failures++;
    end
    checks++;
    sb.delete();
    exp_req = 1'b0;
    #4;
    rst_n = 1'b1;
    tick;
    tick;
    s_valid = 1'b1;
    s_data = 32'hA5A5A5A5;
    sb.push_back(32'hA5A5A5A5);
    tick;
    s_valid = 1'b0;
    exp_req = ~exp_req;
    if (req !== 1'b1 || data_o !== 32'hA5A5A5A5) begin
      $display("FAIL rst_after got req=%0b data=%h exp req=1 data=a5a5a5a5", req, data_o);
      failures++;
    end
    checks++;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick;
      if (done) got = 1'b1;
    end
    if (!got || sb.size() == 0 || data_o !== sb[0]) begin
      $display("FAIL rst_complete got done=%0b data=%h exp done=1 data=a5a5a5a5", got, data_o);
      failures++;
    end
    checks++;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_random;
    int  done_total;
    int  spurious;
    int  d;
    logic got;
    done_total = 0;
    spurious = 0;
    ack_man = exp_req;
    loop_mode = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (s_ready !== 1'b1) begin
        $display("FAIL rnd_ready n=%0d got rdy=%0b exp 1", n, s_ready);
        failures++;
        checks++;
      end
      s_valid = 1'b1;
      s_data = $urandom;
      sb.push_back(s_data);
      tick;
      s_valid = 1'b0;
      exp_req = ~exp_req;
      if (req !== exp_req) begin
        $display("FAIL rnd_req n=%0d got=%0b exp=%0b", n, req, exp_req);
        failures++;
      end
      checks++;
      d = $urandom_range(0, 20);
      for (int i = 0; i < d; i++) begin
        tick;
        if (done) spurious++;
      end
      ack_man = exp_req;
      got = 1'b0;
      for (int k = 0; k < SS + 4 && !got; k++) begin
        tick;
        if (done) got = 1'b1;
      end
      if (got) done_total++;
      if (!got || sb.size() == 0 || data_o !== sb[0] || req !== exp_req) begin
        $display("FAIL rnd_xfer n=%0d got done=%0b data=%h req=%0b exp done=1 data=%h req=%0b",
                 n, got, data_o, req, (sb.size() != 0) ? sb[0] : 32'hx, exp_req);
        failures++;
      end
      checks++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (done_total != 1000 || spurious != 0 || sb.size() != 0) begin
      $display("FAIL rnd_totals got dones=%0d spurious=%0d left=%0d exp 1000/0/0",
               done_total, spurious, sb.size());
      failures++;
    end
    checks++;
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_hold_valid;
    test_timeout;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
